// File: rtl/conv2_maxpool_relu_pkg.sv
// Shared CNN layer constants: sample width and the conv2 / pooled map geometry.
package cnn_pkg;

  localparam int CONV_BIT = 12;

  localparam int CONV2_W  = 8;
  localparam int CONV2_H  = 8;

  localparam int POOL_W   = 4;
  localparam int POOL_H   = 4;
  localparam int POOL_CH  = 3;

endpackage

// File: rtl/conv2_maxpool_relu_if.sv
// conv2 result stream into the pooling stage and the pooled stream out of it.
interface conv2_maxpool_relu_if #(
  parameter int CONV_BIT = cnn_pkg::CONV_BIT
);
  logic                       valid_in;
  logic signed [CONV_BIT-1:0] conv_out_1;
  logic signed [CONV_BIT-1:0] conv_out_2;
  logic signed [CONV_BIT-1:0] conv_out_3;
  logic signed [CONV_BIT-1:0] max_value_1;
  logic signed [CONV_BIT-1:0] max_value_2;
  logic signed [CONV_BIT-1:0] max_value_3;
  logic                       valid_out_relu;

  modport master (
    output valid_in, conv_out_1, conv_out_2, conv_out_3,
    input  max_value_1, max_value_2, max_value_3, valid_out_relu
  );

  modport slave (
    input  valid_in, conv_out_1, conv_out_2, conv_out_3,
    output max_value_1, max_value_2, max_value_3, valid_out_relu
  );
endinterface

// File: rtl/conv2_maxpool_relu_pool_relu_ch.sv
// One channel of 2x2/stride-2 max pooling with ReLU: a hold register for the
// even column and a half-row line buffer of partial maxima.
module pool_relu_ch #(
  parameter int  CONV_BIT   = cnn_pkg::CONV_BIT,
  parameter int  HALF_WIDTH = cnn_pkg::POOL_W,
  localparam int IDX_W      = (HALF_WIDTH > 1) ? $clog2(HALF_WIDTH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic                       col_odd,
  input  logic                       row_odd,
  input  logic [IDX_W-1:0]           buf_idx,
  input  logic signed [CONV_BIT-1:0] data_in,
  output logic signed [CONV_BIT-1:0] data_out,
  output logic                       strobe
);

  logic signed [CONV_BIT-1:0] hold;
  logic signed [CONV_BIT-1:0] linebuf [HALF_WIDTH];
  logic signed [CONV_BIT-1:0] other;
  logic signed [CONV_BIT-1:0] mx;

  // Only the odd-row/even-col step merges with the line buffer; every other
  // max step pairs the incoming sample with the hold register.
  always_comb begin
    other = hold;
    if (row_odd && !col_odd)
      other = linebuf[buf_idx];
    mx = (other > data_in) ? other : data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      data_out <= '0;
      strobe   <= 1'b0;
      for (int unsigned i = 0; i < HALF_WIDTH; i++)
        linebuf[i] <= '0;
    end else begin
      strobe <= 1'b0;
      if (valid_in) begin
        unique case ({row_odd, col_odd})
          2'b00: hold <= data_in;
          2'b01: linebuf[buf_idx] <= mx;
          2'b10: hold <= mx;
          2'b11: begin
            data_out <= mx[CONV_BIT-1] ? '0 : mx;
            strobe   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/conv2_maxpool_relu.sv
// conv2 -> 2x2 max pool -> ReLU for three channels; owns the raster counters.
module conv2_maxpool_relu #(
  parameter int CONV_BIT    = cnn_pkg::CONV_BIT,
  parameter int HALF_WIDTH  = cnn_pkg::POOL_W,
  parameter int HALF_HEIGHT = cnn_pkg::POOL_H
) (
  input logic                     clk,
  input logic                     rst_n,
  conv2_maxpool_relu_if.slave     bus
);

  localparam int COL_W = $clog2(2 * HALF_WIDTH);
  localparam int ROW_W = $clog2(2 * HALF_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(2 * HALF_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(2 * HALF_HEIGHT - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             strobe_1, strobe_2, strobe_3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.valid_in) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  pool_relu_ch #(.CONV_BIT(CONV_BIT), .HALF_WIDTH(HALF_WIDTH)) u_ch1 (
    .clk(clk), .rst_n(rst_n), .valid_in(bus.valid_in),
    .col_odd(col[0]), .row_odd(row[0]), .buf_idx(col[COL_W-1:1]),
    .data_in(bus.conv_out_1), .data_out(bus.max_value_1), .strobe(strobe_1)
  );

  pool_relu_ch #(.CONV_BIT(CONV_BIT), .HALF_WIDTH(HALF_WIDTH)) u_ch2 (
    .clk(clk), .rst_n(rst_n), .valid_in(bus.valid_in),
    .col_odd(col[0]), .row_odd(row[0]), .buf_idx(col[COL_W-1:1]),
    .data_in(bus.conv_out_2), .data_out(bus.max_value_2), .strobe(strobe_2)
  );

  pool_relu_ch #(.CONV_BIT(CONV_BIT), .HALF_WIDTH(HALF_WIDTH)) u_ch3 (
    .clk(clk), .rst_n(rst_n), .valid_in(bus.valid_in),
    .col_odd(col[0]), .row_odd(row[0]), .buf_idx(col[COL_W-1:1]),
    .data_in(bus.conv_out_3), .data_out(bus.max_value_3), .strobe(strobe_3)
  );

  assign bus.valid_out_relu = strobe_1 & strobe_2 & strobe_3;

endmodule

// File: tb/tb_conv2_maxpool_relu.sv
// Bench for conv2_maxpool_relu: frame-level pooling model, window table, and
// reset / gap / back-to-back sequences.
module tb_conv2_maxpool_relu;

  localparam int CB = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  conv2_maxpool_relu_if #(.CONV_BIT(CB)) bus();

  conv2_maxpool_relu #(.CONV_BIT(CB), .HALF_WIDTH(4), .HALF_HEIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int v0; int v1; int v2;} out_t;
  typedef struct {int a; int b; int c; int d; int exp;} vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  out_t exp_q[$];
  out_t got_q[$];
  int   pix [3][8][8];
  int   last_v [3];
  vec_t tbl [8];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int relu_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 0) ? 0 : m;
  endfunction

  function automatic int window(input int ch, input int wr, input int wc);
    return relu_max4(pix[ch][2*wr][2*wc],   pix[ch][2*wr][2*wc+1],
                     pix[ch][2*wr+1][2*wc], pix[ch][2*wr+1][2*wc+1]);
  endfunction

  always @(posedge clk) cyc++;

  // Capture strobes; between strobes the outputs must not move.
  always @(posedge clk) begin
    out_t o;
    #1;
    if (!rst_n) begin
      last_v = '{0, 0, 0};
    end else if (bus.valid_out_relu) begin
      o.cyc = cyc;
      o.v0 = int'(bus.max_value_1);
      o.v1 = int'(bus.max_value_2);
      o.v2 = int'(bus.max_value_3);
      got_q.push_back(o);
      last_v = '{o.v0, o.v1, o.v2};
    end else begin
      chk("hold_1", int'(bus.max_value_1), last_v[0]);
      chk("hold_2", int'(bus.max_value_2), last_v[1]);
      chk("hold_3", int'(bus.max_value_3), last_v[2]);
    end
  end

  function automatic int rand_s12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic fill_ramp(input int offset);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        pix[0][r][c] = 8*r + c + offset;
        pix[1][r][c] = -5;
        pix[2][r][c] = rand_s12();
      end
  endtask

  task automatic fill_random();
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          pix[ch][r][c] = rand_s12();
  endtask

  // gap < 0 selects a random 0..2 idle gap after each pixel.
  task automatic send_frame(input int npix, input int gap);
    out_t e;
    int r, c, g;
    for (int p = 0; p < npix; p++) begin
      r = p / 8;
      c = p % 8;
      @(negedge clk);
      bus.valid_in   = 1'b1;
      bus.conv_out_1 = CB'(pix[0][r][c]);
      bus.conv_out_2 = CB'(pix[1][r][c]);
      bus.conv_out_3 = CB'(pix[2][r][c]);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.cyc = cyc + 1;
        e.v0 = window(0, r/2, c/2);
        e.v1 = window(1, r/2, c/2);
        e.v2 = window(2, r/2, c/2);
        exp_q.push_back(e);
      end
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        @(negedge clk);
        bus.valid_in   = 1'b0;
        bus.conv_out_1 = CB'($urandom);
        bus.conv_out_2 = CB'($urandom);
        bus.conv_out_3 = CB'($urandom);
      end
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_q(input string name);
    int n;
    drain();
    chk({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_cycle"}, got_q[i].cyc, exp_q[i].cyc);
      chk({name, "_ch1"},   got_q[i].v0,  exp_q[i].v0);
      chk({name, "_ch2"},   got_q[i].v1,  exp_q[i].v1);
      chk({name, "_ch3"},   got_q[i].v2,  exp_q[i].v2);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[4];
    tbl[0] = '{-2048,    -1,     3,    -7,    3};
    tbl[1] = '{   -5,    -5,    -5,    -5,    0};
    tbl[2] = '{ 2047, -2048,     0,     0, 2047};
    tbl[3] = '{   -1,    -2,    -3,    -4,    0};
    tbl[4] = '{    0,     0,     0,     0,    0};
    tbl[5] = '{  100,   200,   150,   199,  200};
    tbl[6] = '{-2048,  2047, -2048, -2048, 2047};
    tbl[7] = '{    1, -2048, -2048, -2048,    1};

    bus.valid_in = 1'b0;
    bus.conv_out_1 = '0;
    bus.conv_out_2 = '0;
    bus.conv_out_3 = '0;

    // Reset held while valid_in toggles with data 100.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.valid_in = i[0];
      bus.conv_out_1 = CB'(100);
      bus.conv_out_2 = CB'(100);
      bus.conv_out_3 = CB'(100);
      @(posedge clk);
      #1;
      chk("rst_valid", int'(bus.valid_out_relu), 0);
      chk("rst_mv1", int'(bus.max_value_1), 0);
      chk("rst_mv2", int'(bus.max_value_2), 0);
      chk("rst_mv3", int'(bus.max_value_3), 0);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n = 1'b1;
    chk("rst_no_strobes", got_q.size(), 0);

    // Ramp frame, back-to-back pixels.
    fill_ramp(0);
    send_frame(64, 0);
    drain();
    if (got_q.size() == 16) begin
      chk("ramp_first", got_q[0].v0, 9);
      chk("ramp_fifth", got_q[4].v0, 25);
      chk("ramp_last",  got_q[15].v0, 63);
    end else begin
      chk("ramp_strobes", got_q.size(), 16);
    end
    check_q("ramp");

    // Window table laid across one frame, values rotated per channel.
    for (int k = 0; k < 16; k++) begin
      v = '{tbl[k%8].a, tbl[k%8].b, tbl[k%8].c, tbl[k%8].d};
      for (int ch = 0; ch < 3; ch++)
        for (int p = 0; p < 4; p++)
          pix[ch][2*(k/4) + p/2][2*(k%4) + p%2] = v[(p + ch) % 4];
    end
    send_frame(64, 0);
    drain();
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      chk("tbl_ch1", got_q[k].v0, tbl[k%8].exp);
      chk("tbl_ch2", got_q[k].v1, tbl[k%8].exp);
      chk("tbl_ch3", got_q[k].v2, tbl[k%8].exp);
    end
    check_q("table");

    // Ramp with three idle cycles after every pixel.
    fill_ramp(0);
    send_frame(64, 3);
    check_q("gapped");

    // Two frames with no gap at the boundary.
    fill_ramp(0);
    send_frame(64, 0);
    fill_ramp(100);
    send_frame(64, 0);
    drain();
    if (got_q.size() > 16) chk("b2b_second_first", got_q[16].v0, 109);
    else                   chk("b2b_second_first", -1, 109);
    check_q("b2b");

    // Mid-frame reset after 37 pixels, then a fresh frame.
    fill_random();
    send_frame(37, 0);
    check_q("partial");
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    send_frame(64, 0);
    check_q("after_reset");

    // Random frames with random gaps.
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_frame(64, -1);
    end
    check_q("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2_maxpool_relu.md
# conv2_maxpool_relu

Consumer of the conv2 output stream. Takes the three signed 12-bit conv2 channels in raster order, one pixel per `valid_in`, over an 8×8 map. Applies 2×2 stride-2 max pooling followed by ReLU and emits a 4×4 map per channel, three channels in parallel, as the next stage's input stream. Line buffering is internal: half a row of partial maxima per channel.

## Interface
- `CONV_BIT`, 12: signed data width of the input and output samples.
- `HALF_WIDTH`, 4: pooled map width; the input row is 2*HALF_WIDTH = 8 pixels.
- `HALF_HEIGHT`, 4: pooled map height; the input map has 2*HALF_HEIGHT = 8 rows.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `valid_in` in 1: the conv inputs are valid this cycle.
- `conv_out_1`, `conv_out_2`, `conv_out_3` in CONV_BIT each: signed conv2 results, two's complement.
- `max_value_1`, `max_value_2`, `max_value_3` out CONV_BIT each: pooled, ReLU'd results, registered. Always ≥ 0.
- `valid_out_relu` out 1: one-cycle strobe; the `max_value_*` outputs are valid this cycle.

## Operation
- **Counters.** `col` runs 0..2*HALF_WIDTH-1 and `row` runs 0..2*HALF_HEIGHT-1. They advance only on `valid_in`.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after the last pixel of a frame. Frames are back-to-back with no gap required.
- **Per-channel state.**
  - `hold`: one CONV_BIT register holding the even-column sample.
  - `linebuf[0..HALF_WIDTH-1]`: partial maxima for the current output row.
- **Even row, even col:** `hold <= in`.
- **Even row, odd col:** `linebuf[col>>1] <= smax(hold, in)`.
- **Odd row, even col:** `hold <= smax(linebuf[col>>1], in)`.
- **Odd row, odd col:**
  - result = smax(hold, in).
  - `max_value_n <= (result < 0) ? 0 : result`.
  - Assert `valid_out_relu` for one cycle.
- **Comparison.** `smax` is a signed comparison on the full CONV_BIT width. There is no truncation or rounding; the output width equals the input width.
- **Output rate.** Exactly HALF_WIDTH*HALF_HEIGHT = 16 output strobes per input frame, in raster order of the pooled map.
- **Hold when idle.** With `valid_in` low, all state and outputs hold, except `valid_out_relu`, which returns to 0.
- **Idle-gap tolerance.** Gaps of any length between input pixels do not change the results.

## Timing
- **Reset values.** On `rst_n` low:
  - `col`, `row`, `hold` and `linebuf` clear to 0.
  - `max_value_1..3` = 0.
  - `valid_out_relu` = 0.
- **Latency.** `valid_out_relu` rises on the clock edge that samples the 4th pixel of a window, i.e. 1 cycle after that pixel is presented.
- **Throughput.** One input per cycle, sustained. No backpressure; the downstream stage must accept every strobe.
- **Frame wrap.** The last pixel of the frame (row 7, col 7) produces output 15 of that frame. The next accepted pixel is (0,0) of the new frame. There is no bubble and no stale `linebuf` use, because even rows overwrite `linebuf` before odd rows read it.
- **Reset mid-frame.** The partial frame is discarded. The first `valid_in` after reset is pixel (0,0).
- **Simultaneous events.** An output strobe and a new input in the same cycle are the normal case. The registered output and the `hold` update do not interact.

## Structure
- **Shared package `cnn_pkg`:**
  - `CONV_BIT`.
  - conv2 output map dimensions (8×8).
  - Pooled map dimensions (4×4).
  - Pooled channel count = 3.
- **Sub-module `pool_relu_ch`:** one instance per channel.
  - Contains `hold`, `linebuf`, the signed max logic and the ReLU clamp.
  - Inputs: `col[0]`, `row[0]`, buffer index `col>>1`, `valid_in`, data.
  - Outputs: data and a strobe.
- **Top level:** owns `col`/`row`, instantiates three `pool_relu_ch`, and ANDs the three strobes into `valid_out_relu`. The strobes are identical by construction; the AND matches layer convention.

## Test plan
- **Reset.** Hold `rst_n` low, toggle `valid_in` with data = 100. Required: all outputs 0 and `valid_out_relu` = 0. After release, the first output is still correct.
- **Ramp frame.** Channel 1 pixel (r,c) = 8r+c, 64 consecutive cycles. Required: 16 strobes with values 9, 11, 13, 15, 25, …, 63, each 1 cycle after the odd-row, odd-col pixel.
- **ReLU and sign.**
  - Channel 2: all pixels = -5 (0xFFB). Required: every output 0.
  - Channel 3: window {-2048, -1, 3, -7}. Required: 3, confirming a signed compare, not unsigned.
- **Gapped input.** The ramp frame with `valid_in` low for 3 cycles between every pixel. Required: same 16 values as the ramp frame, strobe spacing 4× wider, outputs held between strobes.
- **Back-to-back frames.** Two ramp frames, the second offset by +100. Required: 32 strobes with no gap at the boundary; the second frame's first output is 109.
- **Mid-frame reset.** Assert `rst_n` low after 37 pixels, then send a full frame. Required: exactly 16 strobes matching the fresh frame, with no carry-over from the aborted frame.
